// File: rtl/rom_table_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rom_table_loader: run-time loadable 16x8 table with combinational read    |
// | port, filled in address order from a valid/ready stream, with checksum.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rom_table_loader #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic [AW-1:0] a,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          done,
  output logic          loaded,
  output logic [DW-1:0] checksum
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] checksum_q, checksum_d;
  logic          loaded_q, loaded_d;
  logic          done_q, done_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    checksum_d = checksum_q;
    loaded_d   = loaded_q;
    done_d     = 1'b0;
    mem_d      = mem_q;
    case (state_q)
      S_IDLE, S_READY: begin
        // Old table contents deliberately survive a new start.
        if (start) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          checksum_d = '0;
          loaded_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (wr_valid) begin
          mem_d[wr_ptr_q] = wr_data;
          wr_ptr_d        = wr_ptr_q + AW'(1);
          checksum_d      = checksum_q + wr_data;
          if (&wr_ptr_q) begin
            state_d  = S_READY;
            loaded_d = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      checksum_q <= '0;
      loaded_q   <= 1'b0;
      done_q     <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      checksum_q <= checksum_d;
      loaded_q   <= loaded_d;
      done_q     <= done_d;
      mem_q      <= mem_d;
    end
  end

  // Ready is a pure decode of the state register, never of wr_valid.
  assign wr_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign done     = done_q;
  assign loaded   = loaded_q;
  assign checksum = checksum_q;
  assign q        = mem_q[a];

endmodule
`default_nettype wire

// File: tb/tb_rom_table_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_rom_table_loader: self-checking bench with a behavioural table model.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_rom_table_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] a;
  logic [DW-1:0] q;
  logic          busy;
  logic          done;
  logic          loaded;
  logic [DW-1:0] checksum;

  rom_table_loader #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .a        (a),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .loaded   (loaded),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain byte array, a load pointer and a running sum.
  int m_mem [DEPTH];
  int m_ptr;
  int m_sum;
  bit m_loading;
  bit m_loaded;
  bit exp_done;

  // Advances the model by one clock edge from the current inputs, then waits
  // for that edge and settles 1 time unit past it.
  task automatic tick();
    exp_done = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
      m_ptr = 0; m_sum = 0; m_loading = 1'b0; m_loaded = 1'b0;
    end else if (m_loading) begin
      if (wr_valid) begin
        m_mem[m_ptr] = int'(wr_data);
        m_sum = (m_sum + int'(wr_data)) % 256;
        if (m_ptr == DEPTH - 1) begin
          m_ptr = 0; m_loading = 1'b0; m_loaded = 1'b1; exp_done = 1'b1;
        end else begin
          m_ptr = m_ptr + 1;
        end
      end
    end else if (start) begin
      m_loading = 1'b1; m_ptr = 0; m_sum = 0; m_loaded = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      n_checks++;
      if (q !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_q a=%0d got %h expected 00", i, q);
      end
    end
    n_checks++;
    if ({wr_ready, busy, loaded, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got rdy/busy/loaded/done=%b expected 0000",
               {wr_ready, busy, loaded, done});
    end
    n_checks++;
    if (checksum !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_checksum got %h expected 00", checksum);
    end
  endtask

  task automatic test_full_load();
    int edges;
    edges = 0;
    start = 1'b1;
    tick();
    edges++;
    start = 1'b0;
    wr_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = DW'(16 + m_ptr);
      tick();
      edges++;
      n_checks++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL full_done edge=%0d got %b expected %b", edges, done, exp_done);
      end
      if (done === 1'b1) break;
    end
    wr_valid = 1'b0;
    // Counted edges include the one that samples start.
    n_checks++;
    if (edges != 17) begin
      n_fail++;
      $display("FAIL full_latency got %0d edges expected 17", edges);
    end
    n_checks++;
    if (loaded !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags got loaded=%b busy=%b expected 1 0", loaded, busy);
    end
    n_checks++;
    if (checksum !== 8'h78) begin
      n_fail++;
      $display("FAIL full_checksum got %h expected 78", checksum);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done_width got %b expected 0", done);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      n_checks++;
      if (q !== DW'(16 + i)) begin
        n_fail++;
        $display("FAIL full_q a=%0d got %h expected %h", i, q, DW'(16 + i));
      end
    end
  endtask

  task automatic test_throttled();
    int done_cnt;
    int dut_writes;
    done_cnt = 0;
    dut_writes = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_data = 8'hFF;
    for (int k = 0; k < 300 && m_loading; k++) begin
      wr_valid = 1'($urandom_range(0, 1));
      #1;
      if (wr_valid && wr_ready) dut_writes++;
      tick();
      if (done === 1'b1) done_cnt++;
      n_checks++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL thr_done got %b expected %b", done, exp_done);
      end
    end
    n_checks++;
    if (m_loading) begin
      n_fail++;
      $display("FAIL thr_timeout got still-loading expected load complete");
    end
    n_checks++;
    if (dut_writes != 16) begin
      n_fail++;
      $display("FAIL thr_writes got %0d expected 16", dut_writes);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL thr_done_count got %0d expected 1", done_cnt);
    end
    n_checks++;
    if (checksum !== 8'hF0) begin
      n_fail++;
      $display("FAIL thr_checksum got %h expected F0", checksum);
    end
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    for (int k = 0; k < 3; k++) tick();
    wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      n_checks++;
      if (q !== 8'hFF) begin
        n_fail++;
        $display("FAIL thr_ready_q a=%0d got %h expected FF", i, q);
      end
    end
    n_checks++;
    if (checksum !== 8'hF0) begin
      n_fail++;
      $display("FAIL thr_ready_checksum got %h expected F0", checksum);
    end
  endtask

  task automatic test_reload_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    for (int k = 0; k < 5; k++) tick();
    wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      n_checks++;
      if (q !== ((i < 5) ? 8'hAA : 8'hFF)) begin
        n_fail++;
        $display("FAIL reload_q a=%0d got %h expected %h", i, q,
                 (i < 5) ? 8'hAA : 8'hFF);
      end
    end
    n_checks++;
    if (loaded !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_flags got loaded=%b busy=%b expected 0 1", loaded, busy);
    end
    n_checks++;
    if (checksum !== 8'h52) begin
      n_fail++;
      $display("FAIL reload_checksum got %h expected 52", checksum);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      n_checks++;
      if (q !== 8'h00) begin
        n_fail++;
        $display("FAIL abort_q a=%0d got %h expected 00", i, q);
      end
    end
    n_checks++;
    if ({wr_ready, busy, loaded, done} !== 4'b0000 || checksum !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_flags got rdy/busy/loaded/done=%b sum=%h expected 0000 00",
               {wr_ready, busy, loaded, done}, checksum);
    end
  endtask

  task automatic test_idle_ignore();
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    for (int k = 0; k < 3; k++) tick();
    wr_valid = 1'b0;
    n_checks++;
    if (checksum !== 8'h00 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore got sum=%h rdy=%b expected 00 0", checksum, wr_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      n_checks++;
      if (q !== DW'(m_mem[i])) begin
        n_fail++;
        $display("FAIL idle_q a=%0d got %h expected %h", i, q, DW'(m_mem[i]));
      end
    end
  endtask

  task automatic test_midload_start_rdw();
    bit seen_done;
    seen_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3) begin
        a = 4'd3;
        wr_data = 8'h3C;
        #1;
        n_checks++;
        if (q !== DW'(m_mem[3])) begin
          n_fail++;
          $display("FAIL rdw_before got %h expected %h", q, DW'(m_mem[3]));
        end
      end else begin
        wr_data = DW'($urandom_range(0, 255));
      end
      start = (i == 7);
      tick();
      start = 1'b0;
      if (done === 1'b1) seen_done = 1'b1;
      if (i == 3) begin
        n_checks++;
        if (q !== 8'h3C) begin
          n_fail++;
          $display("FAIL rdw_after got %h expected 3C", q);
        end
      end
      if (i == 7) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL midstart_busy got %b expected 1", busy);
        end
      end
    end
    wr_valid = 1'b0;
    n_checks++;
    if (!seen_done || loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL midstart_done got done_seen=%b loaded=%b expected 1 1", seen_done, loaded);
    end
    n_checks++;
    if (checksum !== DW'(m_sum)) begin
      n_fail++;
      $display("FAIL midstart_checksum got %h expected %h", checksum, DW'(m_sum));
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      n_checks++;
      if (q !== DW'(m_mem[i])) begin
        n_fail++;
        $display("FAIL midstart_q a=%0d got %h expected %h", i, q, DW'(m_mem[i]));
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    a        = '0;
    m_ptr = 0; m_sum = 0; m_loading = 1'b0; m_loaded = 1'b0; exp_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    test_reset();
    test_full_load();
    test_throttled();
    test_reload_abort();
    test_idle_ignore();
    test_midload_start_rdw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_table_loader.md
Name: rom_table_loader

Overview:
Writer-side companion to the 16x8 combinational lookup ROM. It fills a 16-entry x 8-bit table from a valid/ready byte stream, writing addresses 0..15 in order. It keeps the ROM's combinational read port (a -> q), so it is a drop-in, run-time loadable replacement for the fixed ROM. It also accumulates an 8-bit checksum of the loaded bytes so the host can confirm the load.

Parameters:
AW, 4, address width; table depth is 2**AW.
DW, 8, data width of each entry.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  one-cycle request to begin a full table load.
wr_valid  input  1  wr_data holds a valid byte.
wr_data  input  DW  byte to write at the current load pointer.
wr_ready  output  1  loader accepts a byte this cycle.
a  input  AW  read address.
q  output  DW  table contents at a (combinational).
busy  output  1  load in progress.
done  output  1  one-cycle pulse when the last entry is written.
loaded  output  1  table fully loaded since the last start/reset.
checksum  output  DW  sum of the bytes accepted since start, modulo 2**DW.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): state=IDLE, all table entries=0, wr_ptr=0, checksum=0, wr_ready=0, busy=0, done=0, loaded=0.
  - q therefore reads 0 at every address after reset.
  - Reset asserted mid-load aborts the load and clears all of the above.
- States: IDLE, LOAD, READY.
  - IDLE/READY + start=1 -> LOAD at the next edge. On that edge: wr_ptr=0, checksum=0, loaded=0.
  - Table contents are NOT cleared on start. Old entries stay visible until they are overwritten.
  - start while in LOAD is ignored; the load continues.
  - LOAD + accepted transfer with wr_ptr=2**AW-1 -> READY.
- wr_ready=1 exactly when state==LOAD. It is a registered state decode, with no combinational path from wr_valid.
- Transfer = wr_valid & wr_ready at a clk edge. On a transfer:
  - mem[wr_ptr] <= wr_data
  - wr_ptr <= wr_ptr+1
  - checksum <= checksum + wr_data, truncated to DW bits, with the carry discarded.
- wr_valid=0 in LOAD: no change. Gaps of any length are allowed.
- wr_valid while not in LOAD: ignored. No write, no pointer change, no checksum change.
- Final transfer (wr_ptr=15 for AW=4): on that edge wr_ptr wraps to 0, state=READY, loaded=1, busy=0, and done=1 for exactly one cycle.
- busy=1 exactly when state==LOAD.
- q=mem[a] combinationally in every state, including during LOAD.
  - Read of the address being written in the same cycle returns the old value until the edge, and the new value after it.
- Write latency: a byte is visible on q one edge after its transfer.
- Load time: minimum 17 cycles from the start edge to the done pulse, with wr_valid held high.
- start and reset in the same cycle: reset wins.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then sweep a=0..15 -> q=0x00 at every address; wr_ready=busy=loaded=done=0; checksum=0x00.
- Full load, no gaps: pulse start, then stream bytes 0x10+i for i=0..15 with wr_valid held high.
  - Expect done high for one cycle, 17 cycles after the start edge; loaded=1; busy=0.
  - Expect checksum=0x78, i.e. (16*16+120) mod 256.
  - Sweep a=0..15 -> q=0x10..0x1F.
- Throttled load: toggle wr_valid randomly while loading 0xFF at all 16 entries -> exactly 16 writes; checksum=0xF0; done pulses once; wr_valid sent after READY leaves the table unchanged.
- Reload and abort:
  - After the full load, start again and write 5 bytes of 0xAA -> q=0xAA at a=0..4 and q=original values at a=5..15; loaded=0; busy=1.
  - Then assert rst_n=0 -> q=0x00 at all addresses; state IDLE.
- Ignored events: start pulsed mid-load at wr_ptr=7 -> the pointer continues from 7 and the load completes normally.
- Ignored events: wr_valid=1 in IDLE with wr_data=0x55 -> q unchanged, checksum=0x00.
- Read-during-write: hold a=3 while byte 0x3C is transferred at wr_ptr=3 -> q shows the old value before the edge and 0x3C after it.
